product_accumulator: RTL and testbench



---
 rtl/product_accumulator.sv | 137 +++++++++++++
 tb/tb_product_accumulator.sv | 278 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/product_accumulator.sv
// Sums N_TERMS unsigned 8-bit products into a saturating accumulator per frame.
// Result is registered and held on a valid/ready port. Input is stalled while a result is held.
module product_accumulator #(
  parameter int unsigned N_TERMS = 4,
  parameter int unsigned ACC_W   = 10
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             clear,
  input  logic [7:0]       prod_in,
  input  logic             prod_valid,
  output logic             prod_ready,
  output logic [ACC_W-1:0] acc_out,
  output logic             acc_ovf,
  output logic             acc_valid,
  input  logic             acc_ready
);

  localparam int unsigned CNT_W = $clog2(N_TERMS + 1);
  localparam logic [ACC_W-1:0] SAT_MAX  = '1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(N_TERMS);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_ACCUM = 2'd1,
    S_HOLD  = 2'd2
  } state_t;

  state_t           state_q, state_d;
  logic [ACC_W-1:0] sum_q, sum_d;
  logic             ovf_q, ovf_d;
  logic [CNT_W-1:0] count_q, count_d;
  logic [ACC_W-1:0] acc_out_q, acc_out_d;
  logic             acc_ovf_q, acc_ovf_d;
  logic             acc_valid_q, acc_valid_d;

  logic             accept;
  logic [ACC_W:0]   sum_ext;
  logic             carry;
  logic [ACC_W-1:0] sat_sum;
  logic [CNT_W-1:0] cnt_inc;

  // Ready depends on registered state only, never on prod_valid.
  assign prod_ready = (state_q != S_HOLD);
  assign accept     = prod_valid & prod_ready;

  assign sum_ext = {1'b0, sum_q} + (ACC_W + 1)'(prod_in);
  assign carry   = sum_ext[ACC_W];
  assign sat_sum = carry ? SAT_MAX : sum_ext[ACC_W-1:0];
  assign cnt_inc = count_q + CNT_W'(1);

  always_comb begin
    state_d     = state_q;
    sum_d       = sum_q;
    ovf_d       = ovf_q;
    count_d     = count_q;
    acc_out_d   = acc_out_q;
    acc_ovf_d   = acc_ovf_q;
    acc_valid_d = acc_valid_q;

    if (clear) begin
      state_d     = S_IDLE;
      sum_d       = '0;
      ovf_d       = 1'b0;
      count_d     = '0;
      acc_valid_d = 1'b0;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (accept) begin
            sum_d   = ACC_W'(prod_in);
            ovf_d   = 1'b0;
            count_d = CNT_W'(1);
            if (N_TERMS == 1) begin
              state_d     = S_HOLD;
              acc_out_d   = ACC_W'(prod_in);
              acc_ovf_d   = 1'b0;
              acc_valid_d = 1'b1;
            end else begin
              state_d = S_ACCUM;
            end
          end
        end
        S_ACCUM: begin
          if (accept) begin
            sum_d   = sat_sum;
            ovf_d   = ovf_q | carry;
            count_d = cnt_inc;
            if (cnt_inc == CNT_LAST) begin
              state_d     = S_HOLD;
              acc_out_d   = sat_sum;
              acc_ovf_d   = ovf_q | carry;
              acc_valid_d = 1'b1;
            end
          end
        end
        S_HOLD: begin
          // acc_out/acc_ovf are left as-is so the last result stays readable.
          if (acc_ready) begin
            state_d     = S_IDLE;
            count_d     = '0;
            acc_valid_d = 1'b0;
          end
        end
        default: begin
          state_d     = S_IDLE;
          acc_valid_d = 1'b0;
        end
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= S_IDLE;
      sum_q       <= '0;
      ovf_q       <= 1'b0;
      count_q     <= '0;
      acc_out_q   <= '0;
      acc_ovf_q   <= 1'b0;
      acc_valid_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      sum_q       <= sum_d;
      ovf_q       <= ovf_d;
      count_q     <= count_d;
      acc_out_q   <= acc_out_d;
      acc_ovf_q   <= acc_ovf_d;
      acc_valid_q <= acc_valid_d;
    end
  end

  assign acc_out   = acc_out_q;
  assign acc_ovf   = acc_ovf_q;
  assign acc_valid = acc_valid_q;

endmodule

// File: tb/tb_product_accumulator.sv
// Bench for product_accumulator: a 4-term and an 8-term instance, checked against
// a frame-level model (saturating sum of non-negative terms = min(total, max)).
module tb_product_accumulator;

  localparam int MAXV = 1023;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;

  logic       a_clear = 0, a_prod_valid = 0, a_acc_ready = 0;
  logic [7:0] a_prod_in = 0;
  logic       a_prod_ready, a_acc_ovf, a_acc_valid;
  logic [9:0] a_acc_out;

  logic       b_clear = 0, b_prod_valid = 0, b_acc_ready = 0;
  logic [7:0] b_prod_in = 0;
  logic       b_prod_ready, b_acc_ovf, b_acc_valid;
  logic [9:0] b_acc_out;

  int n_assert = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  product_accumulator #(.N_TERMS(4), .ACC_W(10)) dut_a (
    .clk(clk), .rst_n(rst_n), .clear(a_clear),
    .prod_in(a_prod_in), .prod_valid(a_prod_valid), .prod_ready(a_prod_ready),
    .acc_out(a_acc_out), .acc_ovf(a_acc_ovf), .acc_valid(a_acc_valid),
    .acc_ready(a_acc_ready)
  );

  product_accumulator #(.N_TERMS(8), .ACC_W(10)) dut_b (
    .clk(clk), .rst_n(rst_n), .clear(b_clear),
    .prod_in(b_prod_in), .prod_valid(b_prod_valid), .prod_ready(b_prod_ready),
    .acc_out(b_acc_out), .acc_ovf(b_acc_ovf), .acc_valid(b_acc_valid),
    .acc_ready(b_acc_ready)
  );

  // Drivers are entered and left at a falling edge; one product per call.
  task automatic drive_a(input logic [7:0] p, input int gap);
    int w;
    a_prod_in = p; a_prod_valid = 1'b1; w = 0;
    while (a_prod_ready !== 1'b1 && w < 64) begin @(negedge clk); w++; end
    n_assert++;
    if (w >= 64) begin n_fail++; $display("FAIL accept_timeout_a: prod_ready=%b required 1", a_prod_ready); end
    @(negedge clk);
    a_prod_valid = 1'b0;
    repeat (gap) @(negedge clk);
  endtask

  task automatic drive_b(input logic [7:0] p, input int gap);
    int w;
    b_prod_in = p; b_prod_valid = 1'b1; w = 0;
    while (b_prod_ready !== 1'b1 && w < 64) begin @(negedge clk); w++; end
    n_assert++;
    if (w >= 64) begin n_fail++; $display("FAIL accept_timeout_b: prod_ready=%b required 1", b_prod_ready); end
    @(negedge clk);
    b_prod_valid = 1'b0;
    repeat (gap) @(negedge clk);
  endtask

  task automatic test_reset;
    rst_n = 1'b0;
    repeat (3) @(negedge clk);
    n_assert++; if ({a_acc_valid, a_acc_ovf, a_acc_out} !== 12'd0) begin n_fail++;
      $display("FAIL reset_a_outputs: got valid=%b ovf=%b out=%0d required 0 0 0", a_acc_valid, a_acc_ovf, a_acc_out); end
    n_assert++; if ({b_acc_valid, b_acc_ovf, b_acc_out} !== 12'd0) begin n_fail++;
      $display("FAIL reset_b_outputs: got valid=%b ovf=%b out=%0d required 0 0 0", b_acc_valid, b_acc_ovf, b_acc_out); end
    rst_n = 1'b1;
    @(negedge clk);
    n_assert++; if (a_prod_ready !== 1'b1 || b_prod_ready !== 1'b1) begin n_fail++;
      $display("FAIL reset_prod_ready: got a=%b b=%b required 1 1", a_prod_ready, b_prod_ready); end
  endtask

  task automatic test_back_to_back;
    a_acc_ready = 1'b1;
    for (int i = 0; i < 4; i++) drive_a(8'd12, 0);
    n_assert++; if (a_acc_valid !== 1'b1 || a_acc_out !== 10'd48 || a_acc_ovf !== 1'b0) begin n_fail++;
      $display("FAIL b2b_result: got valid=%b out=%0d ovf=%b required 1 48 0", a_acc_valid, a_acc_out, a_acc_ovf); end
    n_assert++; if (a_prod_ready !== 1'b0) begin n_fail++;
      $display("FAIL b2b_ready_low: got prod_ready=%b required 0", a_prod_ready); end
    @(negedge clk);
    n_assert++; if (a_acc_valid !== 1'b0 || a_prod_ready !== 1'b1 || a_acc_out !== 10'd48) begin n_fail++;
      $display("FAIL b2b_after_handshake: got valid=%b ready=%b out=%0d required 0 1 48", a_acc_valid, a_prod_ready, a_acc_out); end
  endtask

  task automatic test_gaps;
    a_acc_ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      drive_a(8'd225, (i < 3) ? 3 : 0);
      if (i < 3) begin
        n_assert++; if (a_acc_valid !== 1'b0) begin n_fail++;
          $display("FAIL gaps_early_valid: term %0d got acc_valid=%b required 0", i, a_acc_valid); end
      end
    end
    n_assert++; if (a_acc_valid !== 1'b1 || a_acc_out !== 10'd900 || a_acc_ovf !== 1'b0) begin n_fail++;
      $display("FAIL gaps_result: got valid=%b out=%0d ovf=%b required 1 900 0", a_acc_valid, a_acc_out, a_acc_ovf); end
    @(negedge clk);
  endtask

  task automatic test_saturation;
    int total;
    logic [9:0] exp;
    b_acc_ready = 1'b1;
    for (int i = 0; i < 8; i++) drive_b(8'd225, 0);
    n_assert++; if (b_acc_valid !== 1'b1 || b_acc_out !== 10'd1023 || b_acc_ovf !== 1'b1) begin n_fail++;
      $display("FAIL sat_result: got valid=%b out=%0d ovf=%b required 1 1023 1", b_acc_valid, b_acc_out, b_acc_ovf); end
    @(negedge clk);
    // Following non-saturating frame must start with a clean overflow flag.
    total = 0;
    for (int i = 0; i < 8; i++) begin
      logic [7:0] p;
      p = 8'($urandom_range(0, 100));
      total += p;
      drive_b(p, 0);
    end
    exp = 10'(total);
    n_assert++; if (b_acc_out !== exp || b_acc_ovf !== 1'b0) begin n_fail++;
      $display("FAIL sat_next_frame: got out=%0d ovf=%b required %0d 0", b_acc_out, b_acc_ovf, exp); end
    @(negedge clk);
  endtask

  task automatic test_backpressure;
    int total;
    logic [9:0] exp;
    a_acc_ready = 1'b0;
    total = 0;
    for (int i = 0; i < 4; i++) begin
      logic [7:0] p;
      p = 8'($urandom_range(0, 255));
      total += p;
      drive_a(p, 0);
    end
    exp = 10'(total);
    a_prod_in = 8'd77; a_prod_valid = 1'b1;
    for (int c = 0; c < 10; c++) begin
      n_assert++; if (a_acc_valid !== 1'b1 || a_acc_out !== exp || a_prod_ready !== 1'b0) begin n_fail++;
        $display("FAIL bp_hold cycle %0d: got valid=%b out=%0d ready=%b required 1 %0d 0", c, a_acc_valid, a_acc_out, a_prod_ready, exp); end
      @(negedge clk);
    end
    a_acc_ready = 1'b1;
    @(negedge clk);
    n_assert++; if (a_acc_valid !== 1'b0 || a_prod_ready !== 1'b1) begin n_fail++;
      $display("FAIL bp_handshake: got valid=%b ready=%b required 0 1", a_acc_valid, a_prod_ready); end
    total = 77;
    drive_a(8'd77, 0);
    for (int i = 0; i < 3; i++) begin
      logic [7:0] p;
      p = 8'($urandom_range(0, 255));
      total += p;
      drive_a(p, 0);
    end
    exp = 10'(total);
    n_assert++; if (a_acc_valid !== 1'b1 || a_acc_out !== exp || a_acc_ovf !== 1'b0) begin n_fail++;
      $display("FAIL bp_next_frame: got valid=%b out=%0d ovf=%b required 1 %0d 0", a_acc_valid, a_acc_out, a_acc_ovf, exp); end
    @(negedge clk);
  endtask

  task automatic test_clear;
    logic [9:0] last;
    last = a_acc_out;
    a_acc_ready = 1'b1;
    drive_a(8'd12, 0);
    drive_a(8'd12, 0);
    a_prod_in = 8'd12; a_prod_valid = 1'b1; a_clear = 1'b1;
    @(negedge clk);
    a_clear = 1'b0; a_prod_valid = 1'b0;
    n_assert++; if (a_acc_valid !== 1'b0 || a_prod_ready !== 1'b1 || a_acc_out !== last) begin n_fail++;
      $display("FAIL clear_accum: got valid=%b ready=%b out=%0d required 0 1 %0d", a_acc_valid, a_prod_ready, a_acc_out, last); end
    for (int i = 0; i < 4; i++) drive_a(8'd1, 0);
    n_assert++; if (a_acc_valid !== 1'b1 || a_acc_out !== 10'd4 || a_acc_ovf !== 1'b0) begin n_fail++;
      $display("FAIL clear_next_frame: got valid=%b out=%0d ovf=%b required 1 4 0", a_acc_valid, a_acc_out, a_acc_ovf); end
    @(negedge clk);
    a_acc_ready = 1'b0;
    for (int i = 0; i < 4; i++) drive_a(8'd50, 0);
    a_clear = 1'b1; a_acc_ready = 1'b1;
    @(negedge clk);
    a_clear = 1'b0;
    n_assert++; if (a_acc_valid !== 1'b0 || a_acc_out !== 10'd200 || a_prod_ready !== 1'b1) begin n_fail++;
      $display("FAIL clear_hold: got valid=%b out=%0d ready=%b required 0 200 1", a_acc_valid, a_acc_out, a_prod_ready); end
  endtask

  task automatic test_async_reset;
    int total;
    logic [9:0] exp;
    a_acc_ready = 1'b1;
    drive_a(8'd100, 0);
    drive_a(8'd100, 0);
    #2 rst_n = 1'b0;
    #1;
    n_assert++; if ({a_acc_valid, a_acc_ovf, a_acc_out} !== 12'd0) begin n_fail++;
      $display("FAIL arst_accum: got valid=%b ovf=%b out=%0d required 0 0 0", a_acc_valid, a_acc_ovf, a_acc_out); end
    @(negedge clk); rst_n = 1'b1; @(negedge clk);
    a_acc_ready = 1'b0;
    for (int i = 0; i < 4; i++) drive_a(8'd30, 0);
    n_assert++; if (a_acc_valid !== 1'b1 || a_acc_out !== 10'd120) begin n_fail++;
      $display("FAIL arst_frame_after_accum: got valid=%b out=%0d required 1 120", a_acc_valid, a_acc_out); end
    #2 rst_n = 1'b0;
    #1;
    n_assert++; if ({a_acc_valid, a_acc_ovf, a_acc_out} !== 12'd0) begin n_fail++;
      $display("FAIL arst_hold: got valid=%b ovf=%b out=%0d required 0 0 0", a_acc_valid, a_acc_ovf, a_acc_out); end
    @(negedge clk); rst_n = 1'b1; @(negedge clk);
    n_assert++; if (a_prod_ready !== 1'b1) begin n_fail++;
      $display("FAIL arst_ready: got prod_ready=%b required 1", a_prod_ready); end
    a_acc_ready = 1'b1;
    total = 0;
    for (int i = 0; i < 4; i++) begin
      logic [7:0] p;
      p = 8'($urandom_range(0, 255));
      total += p;
      drive_a(p, 0);
    end
    exp = 10'(total);
    n_assert++; if (a_acc_valid !== 1'b1 || a_acc_out !== exp || a_acc_ovf !== 1'b0) begin n_fail++;
      $display("FAIL arst_normal_frame: got valid=%b out=%0d ovf=%b required 1 %0d 0", a_acc_valid, a_acc_out, a_acc_ovf, exp); end
    @(negedge clk);
  endtask

  task automatic test_random;
    int total, dly;
    logic [9:0] exp;
    logic exp_ovf;
    for (int f = 0; f < 6; f++) begin
      dly = $urandom_range(0, 3);
      a_acc_ready = 1'b0;
      total = 0;
      for (int i = 0; i < 4; i++) begin
        logic [7:0] p;
        p = 8'($urandom_range(0, 255));
        total += p;
        drive_a(p, (i < 3) ? $urandom_range(0, 2) : 0);
      end
      exp = 10'(total);
      repeat (dly) @(negedge clk);
      n_assert++; if (a_acc_valid !== 1'b1 || a_acc_out !== exp || a_acc_ovf !== 1'b0) begin n_fail++;
        $display("FAIL rand_a frame %0d: got valid=%b out=%0d ovf=%b required 1 %0d 0", f, a_acc_valid, a_acc_out, a_acc_ovf, exp); end
      a_acc_ready = 1'b1;
      @(negedge clk);
    end
    b_acc_ready = 1'b1;
    for (int f = 0; f < 4; f++) begin
      total = 0;
      for (int i = 0; i < 8; i++) begin
        logic [7:0] p;
        p = 8'($urandom_range(0, 255));
        total += p;
        drive_b(p, $urandom_range(0, 1) * ((i < 7) ? 1 : 0));
      end
      exp     = (total > MAXV) ? 10'(MAXV) : 10'(total);
      exp_ovf = (total > MAXV);
      n_assert++; if (b_acc_valid !== 1'b1 || b_acc_out !== exp || b_acc_ovf !== exp_ovf) begin n_fail++;
        $display("FAIL rand_b frame %0d: got valid=%b out=%0d ovf=%b required 1 %0d %b", f, b_acc_valid, b_acc_out, b_acc_ovf, exp, exp_ovf); end
      @(negedge clk);
    end
  endtask

  initial begin
    test_reset();
    test_back_to_back();
    test_gaps();
    test_saturation();
    test_backpressure();
    test_clear();
    test_async_reset();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

  initial begin
    #500000;
    n_assert++; n_fail++;
    $display("FAIL watchdog: simulation time limit reached, required completion");
    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
